// File: rtl/mux_nx1_stream.sv
// +--------------------------------------------------------------------+
// | mux_nx1_stream: N-input registered stream mux with valid/ready,    |
// | fixed (host-selected) or round-robin channel grant.   Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module mux_nx1_stream #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = 2,
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SELW-1:0] sel,
  input  logic            sel_load,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] cur_sel
);

  localparam logic [SELW:0]   C_N    = (SELW+1)'(N);
  localparam logic [SELW-1:0] C_LAST = SELW'(N-1);

  logic [SELW-1:0] w_grant;
  logic            w_grant_ok;
  logic            w_can_accept;
  logic            w_xfer;
  logic [W-1:0]    w_sel_data;
  logic            w_sel_valid;

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_cur_sel;

  // Output slot frees up in the same cycle the consumer takes the held beat.
  assign w_can_accept = !r_out_valid || out_ready;

  // Explicit compare-and-pick keeps unselected channel data off the output path.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) begin
        w_sel_data  = in_data[i*W +: W];
        w_sel_valid = in_valid[i];
      end
    end
  end

  assign w_xfer = w_can_accept && w_grant_ok && w_sel_valid;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = rst_n && w_can_accept && w_grant_ok && (w_grant == SELW'(gi));
    end
  endgenerate

  generate
    if (MODE == 1) begin : g_rr
      logic [SELW-1:0] r_rr_ptr;
      logic            w_unused_sel;

      assign w_unused_sel = ^{sel_load, sel};

      // Walk offsets from the far end so the nearest valid channel to r_rr_ptr wins.
      always_comb begin
        logic [SELW:0] idx;
        idx        = '0;
        w_grant    = r_rr_ptr;
        w_grant_ok = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
          idx = {1'b0, r_rr_ptr} + (SELW+1)'(k);
          if (idx >= C_N) begin
            idx = idx - C_N;
          end
          for (int j = 0; j < N; j++) begin
            if ((idx == (SELW+1)'(j)) && in_valid[j]) begin
              w_grant    = SELW'(j);
              w_grant_ok = 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rr_ptr  <= '0;
          r_cur_sel <= '0;
        end else if (w_xfer) begin
          r_cur_sel <= w_grant;
          r_rr_ptr  <= (w_grant == C_LAST) ? '0 : w_grant + 1'b1;
        end
      end
    end else begin : g_fixed
      assign w_grant    = r_cur_sel;
      assign w_grant_ok = 1'b1;

      // Out-of-range requests are dropped so the grant always names a real channel.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cur_sel <= '0;
        end else if (sel_load && ({1'b0, sel} < C_N)) begin
          r_cur_sel <= sel;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign cur_sel   = r_cur_sel;

endmodule

`default_nettype wire
